// File: rtl/alu.sv
// Single-cycle registered ALU: add/sub/logic/shift with signed-overflow,
// zero, equality and signed-greater flags, all updated every clock.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       func,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             equals,
    output logic             above
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        F_ADD = 3'b000,
        F_SUB = 3'b001,
        F_AND = 3'b010,
        F_OR  = 3'b011,
        F_XOR = 3'b100,
        F_SLL = 3'b101,
        F_SRA = 3'b110,
        F_RSV = 3'b111
    } func_e;

    logic [WIDTH-1:0] sum, diff, res_next;
    logic [SHW-1:0]   shamt;
    logic             ovf_next;

    assign sum   = op1 + op2;
    assign diff  = op1 - op2;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (func_e'(func))
            F_ADD: begin
                res_next = sum;
                ovf_next = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
            end
            F_SUB: begin
                res_next = diff;
                ovf_next = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
            end
            F_AND:   res_next = op1 & op2;
            F_OR:    res_next = op1 | op2;
            F_XOR:   res_next = op1 ^ op2;
            F_SLL:   res_next = op1 << shamt;
            F_SRA:   res_next = $signed(op1) >>> shamt;
            default: res_next = '0;
        endcase
    end

    // Flags are derived from the same combinational result that gets registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            equals   <= 1'b0;
            above    <= 1'b0;
        end else begin
            result   <= res_next;
            overflow <= ovf_next;
            zero     <= (res_next == '0);
            equals   <= (op1 == op2);
            above    <= ($signed(op1) > $signed(op2));
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized ops
// against an arithmetic reference model with one-cycle latency.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op1, op2;
    logic [2:0]  func;
    logic [31:0] result;
    logic        overflow, zero, equals, above;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        eq;
        logic        above;
    } out_t;

    out_t obs;
    assign obs = '{res: result, ovf: overflow, zero: zero, eq: equals, above: above};

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .func(func),
        .result(result), .overflow(overflow), .zero(zero),
        .equals(equals), .above(above)
    );

    always #5 clk = ~clk;

    // Reference model: signed integer arithmetic in 64 bits, range test for overflow.
    function automatic out_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        longint sa, sb, r, p, lim;
        out_t e;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483647;
        p   = 1;
        for (int i = 0; i < int'(b[4:0]); i++) p = p * 2;
        e.ovf = 1'b0;
        case (f)
            3'd0: begin r = sa + sb; e.ovf = (r > lim) || (r < -lim - 1); end
            3'd1: begin r = sa - sb; e.ovf = (r > lim) || (r < -lim - 1); end
            3'd2: r = longint'({32'd0, a & b});
            3'd3: r = longint'({32'd0, a | b});
            3'd4: r = longint'({32'd0, a ^ b});
            3'd5: r = longint'({32'd0, a}) * p;
            3'd6: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            default: r = 0;
        endcase
        e.res   = r[31:0];
        e.zero  = (e.res == 32'd0);
        e.eq    = (sa == sb);
        e.above = (sa > sb);
        return e;
    endfunction

    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        @(negedge clk);
        rst = r; op1 = a; op2 = b; func = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        out_t exp;
        exp = '0;
        apply(1'b1, 32'h1234_5678, 32'h1111_1111, 3'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, exp);
        end
        apply(1'b1, 32'h5, 32'h5, 3'd7);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_add_sub;
        out_t exp;
        apply(1'b0, 32'h7FFF_FFFF, 32'h1, 3'd0);
        exp = '{res: 32'h8000_0000, ovf: 1'b1, zero: 1'b0, eq: 1'b0, above: 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL add_overflow got=%h want=%h", obs, exp);
        end
        apply(1'b0, 32'd5, 32'd5, 3'd1);
        exp = '{res: 32'h0, ovf: 1'b0, zero: 1'b1, eq: 1'b1, above: 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sub_equal got=%h want=%h", obs, exp);
        end
        apply(1'b0, 32'h8000_0000, 32'h1, 3'd1);
        exp = '{res: 32'h7FFF_FFFF, ovf: 1'b1, zero: 1'b0, eq: 1'b0, above: 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sub_overflow got=%h want=%h", obs, exp);
        end
        apply(1'b0, 32'hFFFF_FFFF, 32'h1, 3'd0);
        exp = '{res: 32'h0, ovf: 1'b0, zero: 1'b1, eq: 1'b0, above: 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL add_wrap got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_compare;
        for (int f = 0; f < 8; f++) begin
            apply(1'b0, 32'hFFFF_FFFF, 32'h1, 3'(f));
            checks++;
            if ({equals, above} !== 2'b00) begin
                errors++;
                $display("FAIL cmp_neg_pos func=%0d got eq/above=%b%b want=00", f, equals, above);
            end
            apply(1'b0, 32'h1, 32'hFFFF_FFFF, 3'(f));
            checks++;
            if ({equals, above} !== 2'b01) begin
                errors++;
                $display("FAIL cmp_pos_neg func=%0d got eq/above=%b%b want=01", f, equals, above);
            end
        end
    endtask

    task automatic test_logic_shift;
        logic [31:0] want [8];
        want[2] = 32'h00F0_F000;
        want[3] = 32'hFFF0_FFF4;
        want[4] = 32'hFF00_0FF4;
        want[5] = 32'h0F0F_0F00;
        want[6] = 32'hFF0F_0F0F;
        want[7] = 32'h0000_0000;
        for (int f = 2; f < 8; f++) begin
            apply(1'b0, 32'hF0F0_F0F0, 32'h0FF0_FF04, 3'(f));
            checks++;
            if (result !== want[f] || overflow !== 1'b0 || zero !== (f == 7)) begin
                errors++;
                $display("FAIL logic_shift func=%0d got=%h ovf=%b z=%b want=%h ovf=0 z=%0d",
                         f, result, overflow, zero, want[f], (f == 7));
            end
        end
    endtask

    task automatic test_reset_midstream;
        out_t exp;
        apply(1'b0, 32'd3, 32'd4, 3'd0);
        exp = '{res: 32'd7, ovf: 1'b0, zero: 1'b0, eq: 1'b0, above: 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pre_reset_add got=%h want=%h", obs, exp);
        end
        apply(1'b1, 32'd3, 32'd4, 3'd0);
        checks++;
        if (obs !== out_t'(0)) begin
            errors++;
            $display("FAIL midstream_reset got=%h want=0", obs);
        end
        apply(1'b0, 32'd30, 32'd20, 3'd0);
        exp = '{res: 32'd50, ovf: 1'b0, zero: 1'b0, eq: 1'b0, above: 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL post_reset_add got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_random;
        out_t exp;
        logic [31:0] a, b;
        for (int f = 0; f < 7; f++) begin
            for (int i = 0; i < 10; i++) begin
                a = $urandom;
                b = (i == 0) ? a : $urandom;
                apply(1'b0, a, b, 3'(f));
                exp = model(a, b, 3'(f));
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random func=%0d a=%h b=%h got=%h want=%h", f, a, b, obs, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        out_t exp;
        logic [31:0] a, b;
        logic [2:0]  f;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 8 == 0) ? a : $urandom;
            f = 3'($urandom_range(0, 7));
            apply(1'b0, a, b, f);
            exp = model(a, b, f);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back func=%0d a=%h b=%h got=%h want=%h", f, a, b, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; op1 = '0; op2 = '0; func = '0;
        test_reset;
        test_add_sub;
        test_compare;
        test_logic_shift;
        test_reset_midstream;
        test_random;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
